fp_div_arbiter: RTL and testbench
=================================

// Module: fp_div_arbiter
// PURPOSE
// - Shares one fully pipelined FloatingDivision unit among NUM_REQ requesters.
// - Round-robin arbitration with a valid/ready handshake per requester.
// - Each accepted operation carries a requester ID through a DIV_LATENCY-deep tag pipe.
// - Results return to the originator, with divide-by-zero detected and overridden here.
// - Sits between the FPU issue logic and the FloatingDivision datapath.
// PARAMETERS
// - XLEN         32  operand/result width (IEEE-754 single; sign 31, exp 30:23, mant 22:0)
// - NUM_REQ      4   number of requesters (>=2)
// - DIV_LATENCY  3   cycles from div_a/div_b applied to div_result valid (>=1)
// - IDW          2   requester ID width, = clog2(NUM_REQ)
// PORTS
// - clk        in   1              clock, rising edge
// - rst        in   1              synchronous reset, active-high
// - req_valid  in   NUM_REQ        per-requester operation request
// - req_a      in   NUM_REQ*XLEN   dividends, requester i at [i*XLEN +: XLEN]
// - req_b      in   NUM_REQ*XLEN   divisors, same packing
// - req_ready  out  NUM_REQ        one-hot grant; transfer = req_valid[i] & req_ready[i]
// - div_a      out  XLEN           registered dividend to FloatingDivision.A
// - div_b      out  XLEN           registered divisor to FloatingDivision.B
// - div_result in   XLEN           FloatingDivision.result
// - rsp_valid  out  1              one-cycle response pulse
// - rsp_id     out  IDW            requester the response belongs to
// - rsp_data   out  XLEN           quotient
// - rsp_dz     out  1              divide-by-zero flag for this response
// - inflight   out  clog2(DIV_LATENCY+2)  operations issued but not yet returned
// BEHAVIOUR
// - Reset (sync, rst=1 at an edge):
//   - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_dz=0.
//   - div_a=div_b=0, inflight=0, RR pointer=0.
//   - All tag-pipe valid bits cleared.
// - Reset mid-operation: in-flight ops are dropped and no rsp is produced for them.
// - req_ready (combinational):
//   - Grant the first i with req_valid[i]=1, searching from ptr upward, modulo NUM_REQ.
//   - Zero when no request is valid or rst=1. At most one bit set.
// - Grant edge E0 (transfer occurs):
//   - div_a<=req_a[i], div_b<=req_b[i].
//   - tag stage 0 <= {valid=1, id=i, dz, sign}.
//   - ptr<=(i+1) mod NUM_REQ.
// - No transfer: div_a/div_b hold their values; tag stage 0 valid<=0; ptr unchanged.
// - Tag pipe: DIV_LATENCY stages, shifted every cycle with no stall.
//   - Throughput: 1 op/cycle.
// - Divide-by-zero: dz = (req_b[i][30:0]==0), i.e. +0 or -0 divisor.
//   - sign = req_a[i][31]^req_b[i][31].
// - Response at edge E0+DIV_LATENCY, captured from the last tag stage:
//   - rsp_valid<=last.valid.
//   - rsp_data<=last.dz ? {sign,8'hFF,23'b0} : div_result.
//   - rsp_dz<=last.dz & last.valid.
//   - rsp_id<=last.id.
//   - rsp_id and rsp_data hold their previous values when last.valid=0.
// - Latency: rsp_valid is high in the cycle DIV_LATENCY+1 clocks after the acceptance cycle.
// - Responses have no backpressure; requesters must always sink them.
// - inflight: +1 on transfer, -1 on rsp_valid capture, net 0 when both happen on the same edge.
//   - Never exceeds DIV_LATENCY+1.
// - A requester must hold req_a/req_b stable while req_valid=1 and req_ready=0.
//   - After a transfer it may change them or drop req_valid.
// - A requester holding req_valid back-to-back is re-granted only after every other valid requester has been served once.
// TESTING
// - Single op: req_valid=4'b0001, A=0x40866666 (4.2), B=0x404CCCCC (3.2).
//   - Expect req_ready=0001 for 1 cycle.
//   - Expect div_a/div_b = those values.
//   - Expect rsp_valid DIV_LATENCY+1 cycles later with rsp_id=0 and rsp_data=div_result (~0x3FA80000, 1.3125).
// - Contention: req_valid=4'b1111 held with ptr=0.
//   - Expect grants 0001,0010,0100,1000,0001 on consecutive cycles.
//   - Expect rsp_id 0,1,2,3 in the same order, back-to-back.
// - Fairness: req 2 holds valid; req 0 pulses valid every cycle.
//   - Expect grants to alternate between 2 and 0.
// - Divide by zero: A=0x40CCCCCD (6.4), B=0x80000000 (-0).
//   - Expect rsp_data=0xFF800000 and rsp_dz=1.
//   - Then A=0x40CCCCCD, B=0x00000000 gives rsp_data=0x7F800000.
// - Reset mid-flight: issue 3 ops, assert rst 1 cycle after the 3rd grant.
//   - Expect no rsp_valid afterwards, inflight=0, ptr=0.
//   - Next request from req 3 is granted next cycle.
// - inflight: continuous 1 op/cycle.
//   - Expect inflight to ramp to DIV_LATENCY+1 and hold.
//   - Expect it to fall by 1 per cycle to 0 after requests stop.

Source files
------------

// File: rtl/fp_div_arbiter.sv
// Purpose : round-robin front end that shares one pipelined FP divider among NUM_REQ requesters.
// Latency : operands reach the divider 1 cycle after acceptance; rsp_valid is high DIV_LATENCY+1 cycles after acceptance.
// Backpres: one request accepted per cycle via one-hot req_ready; responses are never stalled.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_a/req_b  per-requester operation (operands packed XLEN per requester)
//   req_ready            one-hot combinational grant
//   div_a/div_b          registered operands to the divider
//   div_result           divider quotient, valid DIV_LATENCY cycles after div_a/div_b
//   rsp_valid/rsp_id/rsp_data/rsp_dz  one-cycle response with divide-by-zero override
//   inflight             operations accepted but whose response cycle has not yet completed
module fp_div_arbiter #(
  parameter int XLEN        = 32,
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 3,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*XLEN-1:0]            req_a,
  input  logic [NUM_REQ*XLEN-1:0]            req_b,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [XLEN-1:0]                    div_a,
  output logic [XLEN-1:0]                    div_b,
  input  logic [XLEN-1:0]                    div_result,
  output logic                               rsp_valid,
  output logic [IDW-1:0]                     rsp_id,
  output logic [XLEN-1:0]                    rsp_data,
  output logic                               rsp_dz,
  output logic [$clog2(DIV_LATENCY+2)-1:0]   inflight
);

  localparam int CW   = $clog2(DIV_LATENCY+2);
  localparam int EXPW = 8;
  localparam int MANW = XLEN - 1 - EXPW;

  // Arbitration state and divider operand registers
  logic [IDW-1:0]         r_ptr;
  logic [XLEN-1:0]        r_div_a;
  logic [XLEN-1:0]        r_div_b;

  // Tag pipe travelling alongside the divider
  logic [DIV_LATENCY-1:0] r_tag_vld;
  logic [DIV_LATENCY-1:0] r_tag_dz;
  logic [DIV_LATENCY-1:0] r_tag_sgn;
  logic [IDW-1:0]         r_tag_id [DIV_LATENCY];

  // Response registers
  logic                   r_rsp_vld;
  logic [IDW-1:0]         r_rsp_id;
  logic [XLEN-1:0]        r_rsp_data;
  logic                   r_rsp_dz;
  logic [CW-1:0]          r_inflight;

  // Combinational grant
  logic                   w_found;
  logic                   w_xfer;
  logic [IDW-1:0]         w_gnt_id;
  logic [IDW:0]           w_idx;
  logic [NUM_REQ-1:0]     w_grant;
  logic [XLEN-1:0]        w_sel_a;
  logic [XLEN-1:0]        w_sel_b;
  logic                   w_dz;
  logic                   w_sgn;
  logic                   w_last_vld;

  // Search upward from r_ptr with wraparound; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[IDW-1:0];
      end
    end
    w_xfer  = w_found & ~rst;
    w_grant = w_xfer ? (NUM_REQ'(1) << w_gnt_id) : '0;
  end

  assign w_sel_a    = req_a[w_gnt_id*XLEN +: XLEN];
  assign w_sel_b    = req_b[w_gnt_id*XLEN +: XLEN];
  // Both +0 and -0 divisors count as zero; the sign of the infinity follows the quotient sign.
  assign w_dz       = (w_sel_b[XLEN-2:0] == '0);
  assign w_sgn      = w_sel_a[XLEN-1] ^ w_sel_b[XLEN-1];
  assign w_last_vld = r_tag_vld[DIV_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_tag_vld  <= '0;
      r_tag_dz   <= '0;
      r_tag_sgn  <= '0;
      for (int k = 0; k < DIV_LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_dz   <= 1'b0;
      r_inflight <= '0;
    end else begin
      if (w_xfer) begin
        r_div_a <= w_sel_a;
        r_div_b <= w_sel_b;
        if (w_gnt_id == IDW'(NUM_REQ-1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_gnt_id + IDW'(1);
        end
      end

      // Tag pipe shifts every cycle; only the valid bit matters when no transfer happened.
      r_tag_vld[0] <= w_xfer;
      r_tag_dz[0]  <= w_dz;
      r_tag_sgn[0] <= w_sgn;
      r_tag_id[0]  <= w_gnt_id;
      for (int k = 1; k < DIV_LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_dz[k]  <= r_tag_dz[k-1];
        r_tag_sgn[k] <= r_tag_sgn[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end

      r_rsp_vld <= w_last_vld;
      r_rsp_dz  <= w_last_vld & r_tag_dz[DIV_LATENCY-1];
      if (w_last_vld) begin
        r_rsp_id   <= r_tag_id[DIV_LATENCY-1];
        r_rsp_data <= r_tag_dz[DIV_LATENCY-1]
                      ? {r_tag_sgn[DIV_LATENCY-1], {EXPW{1'b1}}, {MANW{1'b0}}}
                      : div_result;
      end

      // An operation stops counting once its response cycle has completed.
      case ({w_xfer, r_rsp_vld})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign rsp_valid = r_rsp_vld;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_dz    = r_rsp_dz;
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Purpose : self-checking bench for fp_div_arbiter with a stub pipelined divider.
// Latency : stub divider returns a quotient DIV_LATENCY cycles after div_a/div_b.
// Backpres: bench always sinks responses.
module tb_fp_div_arbiter;
  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int CW   = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*XLEN-1:0]   req_a;
  logic [NREQ*XLEN-1:0]   req_b;
  logic [NREQ-1:0]        req_ready;
  logic [XLEN-1:0]        div_a;
  logic [XLEN-1:0]        div_b;
  logic [XLEN-1:0]        div_result;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [XLEN-1:0]        rsp_data;
  logic                   rsp_dz;
  logic [CW-1:0]          inflight;

  always #5 clk = ~clk;

  fp_div_arbiter #(
    .XLEN(XLEN), .NUM_REQ(NREQ), .DIV_LATENCY(LAT), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
    .inflight(inflight)
  );

  // Stub divider: the known 4.2/3.2 pair returns 1.3125, everything else a distinctive mix.
  function automatic logic [31:0] stub_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40866666 && b == 32'h404CCCCC) return 32'h3FA80000;
    return a ^ {b[7:0], b[31:8]} ^ 32'h1234_5678;
  endfunction

  logic [XLEN-1:0] dpipe [LAT-1];
  always @(posedge clk) begin
    dpipe[0] <= stub_div(div_a, div_b);
    for (int k = 1; k < LAT-1; k++) dpipe[k] <= dpipe[k-1];
  end
  assign div_result = dpipe[LAT-2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
    logic        dz;
  } exp_t;
  exp_t        q[$];
  int          m_ptr       = 0;
  logic [31:0] m_div_a     = '0;
  logic [31:0] m_div_b     = '0;
  int          m_last_id   = 0;
  logic [31:0] m_last_data = '0;
  int          ncyc        = 0;
  logic        chk_en      = 1'b0;

  // Logs of what the DUT actually did, for hand-computed expectations
  int          gnt_val[$];
  int          gnt_cyc[$];
  int          rsp_id_log[$];
  int          rsp_cyc_log[$];
  logic [31:0] rsp_data_log[$];
  logic        rsp_dz_log[$];

  function automatic int gv(input int i);
    if (i < gnt_val.size()) return gnt_val[i];
    return -1;
  endfunction
  function automatic int gc(input int i);
    if (i < gnt_cyc.size()) return gnt_cyc[i];
    return -1000;
  endfunction
  function automatic int rv(input int i);
    if (i < rsp_id_log.size()) return rsp_id_log[i];
    return -1;
  endfunction
  function automatic int rc(input int i);
    if (i < rsp_cyc_log.size()) return rsp_cyc_log[i];
    return -1000;
  endfunction
  function automatic logic [31:0] rd(input int i);
    if (i < rsp_data_log.size()) return rsp_data_log[i];
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic rz(input int i);
    if (i < rsp_dz_log.size()) return rsp_dz_log[i];
    return 1'bx;
  endfunction

  always @(negedge clk) begin : chk_proc
    logic [NREQ-1:0] e_gnt;
    logic            found;
    int              gid;
    int              j;
    int              e_infl;
    exp_t            e;
    logic [31:0]     a;
    logic [31:0]     b;
    if (chk_en) begin
      e_gnt = '0;
      found = 1'b0;
      gid   = 0;
      if (!rst) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (!found && req_valid[j]) begin
            found    = 1'b1;
            gid      = j;
            e_gnt[j] = 1'b1;
          end
        end
      end
      check("req_ready", req_ready, e_gnt);
      if (req_ready != '0) begin
        gnt_val.push_back(int'(req_ready));
        gnt_cyc.push_back(ncyc);
      end
      if (rsp_valid === 1'b1) begin
        rsp_id_log.push_back(int'(rsp_id));
        rsp_data_log.push_back(rsp_data);
        rsp_dz_log.push_back(rsp_dz);
        rsp_cyc_log.push_back(ncyc);
      end

      e_infl = q.size();
      if (q.size() != 0 && q[0].due == ncyc) begin
        e = q.pop_front();
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_dz", rsp_dz, e.dz);
        m_last_id   = e.id;
        m_last_data = e.data;
      end else begin
        check("rsp_valid_idle", rsp_valid, 1'b0);
        check("rsp_dz_idle", rsp_dz, 1'b0);
        check("rsp_id_hold", rsp_id, m_last_id);
        check("rsp_data_hold", rsp_data, m_last_data);
      end
      check("inflight", inflight, e_infl);
      check("div_a", div_a, m_div_a);
      check("div_b", div_b, m_div_b);

      // Model update for the coming edge
      if (rst) begin
        q.delete();
        m_ptr       = 0;
        m_div_a     = '0;
        m_div_b     = '0;
        m_last_id   = 0;
        m_last_data = '0;
      end else if (found) begin
        a      = req_a[gid*XLEN +: XLEN];
        b      = req_b[gid*XLEN +: XLEN];
        e.due  = ncyc + 1 + LAT;
        e.id   = gid;
        e.dz   = (b[30:0] == 31'd0);
        e.data = e.dz ? {a[31] ^ b[31], 8'hFF, 23'd0} : stub_div(a, b);
        q.push_back(e);
        m_ptr   = (gid + 1) % NREQ;
        m_div_a = a;
        m_div_b = b;
      end
    end
    ncyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
  endtask

  int g0;
  int r0;
  int infl_exp [16] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0};
  int exp_c [5]     = '{1, 2, 4, 8, 1};
  int exp_ci [5]    = '{0, 1, 2, 3, 0};
  int exp_f [4]     = '{4, 1, 4, 1};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_dz", rsp_dz, 1'b0);
    check("reset_div_a", div_a, 0);
    check("reset_div_b", div_b, 0);
    check("reset_inflight", inflight, 0);
    check("reset_req_ready", req_ready, 0);

    // Single op from requester 0
    g0 = gnt_val.size();
    r0 = rsp_id_log.size();
    set_op(0, 32'h40866666, 32'h404CCCCC);
    req_valid = 4'b0001;
    #1 check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    check("t1_ready_drop", req_ready, 0);
    check("t1_div_a", div_a, 32'h40866666);
    check("t1_div_b", div_b, 32'h404CCCCC);
    repeat (8) tick();
    check("t1_rsp_count", rsp_id_log.size() - r0, 1);
    check("t1_rsp_data", rd(r0), 32'h3FA80000);
    check("t1_rsp_id", rv(r0), 0);
    check("t1_latency", rc(r0) - gc(g0), LAT + 1);

    // Contention with pointer at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3F800000 + (i << 20), 32'h40000000 + (i << 16) + 5);
    g0 = gnt_val.size();
    r0 = rsp_id_log.size();
    req_valid = 4'b1111;
    repeat (5) tick();
    req_valid = '0;
    repeat (8) tick();
    for (int k = 0; k < 5; k++) begin
      check("t2_grant", gv(g0 + k), exp_c[k]);
      check("t2_rsp_id", rv(r0 + k), exp_ci[k]);
    end
    check("t2_rsp_back_to_back", rc(r0 + 4) - rc(r0), 4);

    // Fairness: requester 2 held, requester 0 valid every cycle
    g0 = gnt_val.size();
    req_valid = 4'b0101;
    repeat (4) tick();
    req_valid = '0;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) check("t3_grant", gv(g0 + k), exp_f[k]);

    // Divide by -0 then +0
    r0 = rsp_id_log.size();
    set_op(1, 32'h40CCCCCD, 32'h80000000);
    req_valid = 4'b0010;
    tick();
    set_op(1, 32'h40CCCCCD, 32'h00000000);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check("t4_dz_neg_data", rd(r0), 32'hFF800000);
    check("t4_dz_neg_flag", rz(r0), 1'b1);
    check("t4_dz_pos_data", rd(r0 + 1), 32'h7F800000);
    check("t4_dz_pos_flag", rz(r0 + 1), 1'b1);

    // Reset with three ops in flight
    r0 = rsp_id_log.size();
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("t5_inflight_after_rst", inflight, 0);
    repeat (6) tick();
    check("t5_no_rsp", rsp_id_log.size() - r0, 0);
    set_op(3, 32'h41200000, 32'h40A00000);
    req_valid = 4'b1000;
    #1 check("t5_req3_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check("t5_req3_rsp_id", rv(r0), 3);

    // Continuous issue: inflight ramp, plateau and drain
    req_valid = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) req_valid = '0;
      #1;
      check("t6_inflight", inflight, infl_exp[i]);
    end
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
